// File: rtl/dbg_frame_tx.sv
// dbg_frame_tx: debug snapshot transmitter for the MU0 board.
// A trigger in IDLE latches the CPU debug buses into a snapshot. The snapshot
// is then sent as a 13-byte frame on a UART 8N1 line: sync byte, 11 payload
// bytes (pc, acc, ir, state, alu result, alu op) and a mod-256 checksum of
// the payload.
//
// Ports:
//   clk          - system clock
//   reset        - asynchronous, active-high reset
//   trigger      - single-cycle capture request
//   dbgPc        - program counter            (16)
//   dbgAcc       - accumulator                (16)
//   dbgIr        - instruction register       (16)
//   dbgState     - core state vector          (9)
//   dbgAluResult - ALU result                 (16)
//   dbgAluOp     - ALU opcode                 (4)
//   tx           - UART serial out, idles high (registered)
//   busy         - frame in progress (registered)
//   frame_done   - one-cycle pulse as the last stop bit completes (registered)
//   overrun      - one-cycle pulse for a trigger that arrives while busy (registered)

module dbg_frame_tx #(
   parameter int unsigned CLKS_PER_BIT = 234,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        trigger,
   input  logic [15:0] dbgPc,
   input  logic [15:0] dbgAcc,
   input  logic [15:0] dbgIr,
   input  logic [8:0]  dbgState,
   input  logic [15:0] dbgAluResult,
   input  logic [3:0]  dbgAluOp,
   output logic        tx,
   output logic        busy,
   output logic        frame_done,
   output logic        overrun
);

   localparam int unsigned BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned LAST_BYTE = 12;
   localparam int unsigned LAST_BIT  = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t              state, state_nx;
   logic [BAUD_W-1:0]   baud_cnt, baud_nx;
   logic [2:0]          bit_idx, bit_nx;
   logic [3:0]          byte_idx, byte_nx;
   logic                load_snap;
   logic                baud_end;

   logic [15:0]         snap_pc, snap_acc, snap_ir, snap_res;
   logic [8:0]          snap_state;
   logic [3:0]          snap_op;

   logic [7:0]          chk;
   logic [7:0]          byte_sel;
   logic                tx_nx, busy_nx, done_nx, ovr_nx;

   // State register, counters, snapshot and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         byte_idx   <= '0;
         snap_pc    <= '0;
         snap_acc   <= '0;
         snap_ir    <= '0;
         snap_state <= '0;
         snap_res   <= '0;
         snap_op    <= '0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_nx;
         baud_cnt   <= baud_nx;
         bit_idx    <= bit_nx;
         byte_idx   <= byte_nx;
         if (load_snap) begin
            snap_pc    <= dbgPc;
            snap_acc   <= dbgAcc;
            snap_ir    <= dbgIr;
            snap_state <= dbgState;
            snap_res   <= dbgAluResult;
            snap_op    <= dbgAluOp;
         end
         tx         <= tx_nx;
         busy       <= busy_nx;
         frame_done <= done_nx;
         overrun    <= ovr_nx;
      end
   end

   // Next-state and counter logic; the baud counter wraps at CLKS_PER_BIT-1
   always_comb begin
      state_nx  = state;
      baud_nx   = baud_cnt;
      bit_nx    = bit_idx;
      byte_nx   = byte_idx;
      load_snap = 1'b0;
      baud_end  = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

      if (state != IDLE) begin
         baud_nx = baud_end ? '0 : baud_cnt + BAUD_W'(1);
      end

      case (state)
         IDLE: begin
            if (trigger) begin
               state_nx  = START;
               baud_nx   = '0;
               bit_nx    = '0;
               byte_nx   = '0;
               load_snap = 1'b1;
            end
         end
         START: begin
            if (baud_end) begin
               state_nx = DATA;
               bit_nx   = '0;
            end
         end
         DATA: begin
            if (baud_end) begin
               if (bit_idx == 3'(LAST_BIT)) begin
                  state_nx = STOP;
               end else begin
                  bit_nx = bit_idx + 3'd1;
               end
            end
         end
         STOP: begin
            if (baud_end) begin
               if (byte_idx == 4'(LAST_BYTE)) begin
                  state_nx = IDLE;
               end else begin
                  state_nx = START;
                  byte_nx  = byte_idx + 4'd1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Payload checksum: 8-bit sum of the 11 payload bytes (sync excluded)
   always_comb begin
      chk = snap_pc[15:8]  + snap_pc[7:0]
          + snap_acc[15:8] + snap_acc[7:0]
          + snap_ir[15:8]  + snap_ir[7:0]
          + {7'b0, snap_state[8]} + snap_state[7:0]
          + snap_res[15:8] + snap_res[7:0]
          + {4'b0, snap_op};
   end

   // Output logic: next values of the registered outputs, from the next state
   always_comb begin
      byte_sel = chk;
      case (byte_nx)
         4'd0:    byte_sel = SYNC_BYTE;
         4'd1:    byte_sel = snap_pc[15:8];
         4'd2:    byte_sel = snap_pc[7:0];
         4'd3:    byte_sel = snap_acc[15:8];
         4'd4:    byte_sel = snap_acc[7:0];
         4'd5:    byte_sel = snap_ir[15:8];
         4'd6:    byte_sel = snap_ir[7:0];
         4'd7:    byte_sel = {7'b0, snap_state[8]};
         4'd8:    byte_sel = snap_state[7:0];
         4'd9:    byte_sel = snap_res[15:8];
         4'd10:   byte_sel = snap_res[7:0];
         4'd11:   byte_sel = {4'b0, snap_op};
         default: byte_sel = chk;
      endcase

      tx_nx = 1'b1;
      case (state_nx)
         START:   tx_nx = 1'b0;
         DATA:    tx_nx = byte_sel[bit_nx];
         default: tx_nx = 1'b1;
      endcase

      busy_nx = (state_nx != IDLE);
      // Completion is the STOP -> IDLE transition of the last byte
      done_nx = (state == STOP) && (state_nx == IDLE);
      // Only a registered IDLE accepts a trigger, including the done cycle
      ovr_nx  = trigger && (state != IDLE);
   end

endmodule

// File: tb/tb_dbg_frame_tx.sv
// tb_dbg_frame_tx: self-checking bench for dbg_frame_tx.
// Two instances: CLKS_PER_BIT=4 for most scenarios, CLKS_PER_BIT=7 for the
// bit-timing / checksum-wrap scenario. Expected frames come from a byte-level
// model of the frame format; the line is captured every cycle and compared
// against the ideal bit stream and decoded back to bytes.

module tb_dbg_frame_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic        trig4, trig7;
   logic [15:0] pc, acc, ir, res;
   logic [8:0]  st;
   logic [3:0]  op;
   logic        tx4, busy4, done4, ovr4;
   logic        tx7, busy7, done7, ovr7;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_q [13];
   logic [7:0] got   [13];
   bit cap_tx   [1024];
   bit cap_busy [1024];
   bit cap_done [1024];
   bit cap_ovr  [1024];

   always #5 clk = ~clk;

   dbg_frame_tx #(.CLKS_PER_BIT(4), .SYNC_BYTE(8'hA5)) u4 (
      .clk(clk), .reset(reset), .trigger(trig4),
      .dbgPc(pc), .dbgAcc(acc), .dbgIr(ir), .dbgState(st),
      .dbgAluResult(res), .dbgAluOp(op),
      .tx(tx4), .busy(busy4), .frame_done(done4), .overrun(ovr4)
   );

   dbg_frame_tx #(.CLKS_PER_BIT(7), .SYNC_BYTE(8'hA5)) u7 (
      .clk(clk), .reset(reset), .trigger(trig7),
      .dbgPc(pc), .dbgAcc(acc), .dbgIr(ir), .dbgState(st),
      .dbgAluResult(res), .dbgAluOp(op),
      .tx(tx7), .busy(busy7), .frame_done(done7), .overrun(ovr7)
   );

   // Reference model: frame bytes straight from the format description
   task automatic model_frame(input logic [15:0] p, input logic [15:0] a,
                              input logic [15:0] r, input logic [15:0] q,
                              input logic [8:0] s, input logic [3:0] o);
      logic [7:0] payload [11];
      int sum;
      payload = '{p[15:8], p[7:0], a[15:8], a[7:0], r[15:8], r[7:0],
                  {7'b0, s[8]}, s[7:0], q[15:8], q[7:0], {4'b0, o}};
      sum = 0;
      exp_q[0] = 8'hA5;
      for (int i = 0; i < 11; i++) begin
         exp_q[i+1] = payload[i];
         sum = sum + int'(payload[i]);
      end
      exp_q[12] = 8'(sum % 256);
   endtask

   // Ideal line level at cycle k of a frame (k=0 is the first cycle after the trigger edge)
   function automatic logic exp_bit(input int k, input int cpb);
      int b, pos, by;
      logic [7:0] v;
      b   = k / cpb;
      pos = b % 10;
      by  = b / 10;
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      v = exp_q[by];
      return v[pos-1];
   endfunction

   task automatic rand_inputs();
      pc  = 16'($urandom);
      acc = 16'($urandom);
      ir  = 16'($urandom);
      res = 16'($urandom);
      st  = 9'($urandom);
      op  = 4'($urandom);
   endtask

   // Called at a negedge; returns at the negedge after the trigger edge
   task automatic start_frame(input bit sel);
      if (sel) trig7 = 1'b1; else trig4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      trig4 = 1'b0;
      trig7 = 1'b0;
   endtask

   // Record outputs each cycle for 130*cpb+tail+1 samples; optional retriggers and input scramble
   task automatic capture(input bit sel, input int cpb, input int tail,
                          input int rt_a, input int rt_b, input bit scramble);
      int n;
      n = 130 * cpb + tail;
      for (int k = 0; k <= n; k++) begin
         if (k > 0) @(negedge clk);
         cap_tx[k]   = sel ? tx7   : tx4;
         cap_busy[k] = sel ? busy7 : busy4;
         cap_done[k] = sel ? done7 : done4;
         cap_ovr[k]  = sel ? ovr7  : ovr4;
         if (scramble && k == 0) begin
            pc  = pc  ^ (16'($urandom) | 16'h1);
            acc = acc ^ (16'($urandom) | 16'h1);
            ir  = ir  ^ (16'($urandom) | 16'h1);
            res = res ^ (16'($urandom) | 16'h1);
            st  = st  ^ (9'($urandom)  | 9'h1);
            op  = op  ^ (4'($urandom)  | 4'h1);
         end
         if (sel) trig7 = (k == rt_a) || (k == rt_b);
         else     trig4 = (k == rt_a) || (k == rt_b);
      end
      trig4 = 1'b0;
      trig7 = 1'b0;
      for (int i = 0; i < 13; i++)
         for (int j = 0; j < 8; j++)
            got[i][j] = cap_tx[(i*10 + 1 + j)*cpb + cpb/2];
   endtask

   task automatic test_reset();
      reset = 1'b1;
      trig4 = 1'b0;
      trig7 = 1'b0;
      pc = '0; acc = '0; ir = '0; res = '0; st = '0; op = '0;
      repeat (3) @(negedge clk);
      n_checks++; if (tx4 !== 1'b1)   begin n_fail++; $display("FAIL reset_tx4: got %b expected 1", tx4); end
      n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy4: got %b expected 0", busy4); end
      n_checks++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL reset_done4: got %b expected 0", done4); end
      n_checks++; if (ovr4 !== 1'b0)  begin n_fail++; $display("FAIL reset_ovr4: got %b expected 0", ovr4); end
      n_checks++; if (tx7 !== 1'b1)   begin n_fail++; $display("FAIL reset_tx7: got %b expected 1", tx7); end
      n_checks++; if (busy7 !== 1'b0) begin n_fail++; $display("FAIL reset_busy7: got %b expected 0", busy7); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (tx4 !== 1'b1 || busy4 !== 1'b0) begin
         n_fail++; $display("FAIL idle_after_reset: tx=%b busy=%b expected tx=1 busy=0", tx4, busy4);
      end
   endtask

   task automatic test_reference();
      logic [7:0] ref_b [13];
      int busy_cnt, done_cnt, errs, first_bad;
      ref_b = '{8'hA5, 8'h00, 8'h12, 8'hBE, 8'hEF, 8'h30, 8'h04,
                8'h01, 8'h01, 8'h00, 8'hFF, 8'h07, 8'hFB};
      pc = 16'h0012; acc = 16'hBEEF; ir = 16'h3004; st = 9'h101; res = 16'h00FF; op = 4'h7;
      exp_q = ref_b;
      start_frame(1'b0);
      capture(1'b0, 4, 3, -1, -1, 1'b0);
      for (int i = 0; i < 13; i++) begin
         n_checks++; if (got[i] !== ref_b[i]) begin
            n_fail++; $display("FAIL ref_byte%0d: got %h expected %h", i, got[i], ref_b[i]);
         end
      end
      busy_cnt = 0; done_cnt = 0; errs = 0; first_bad = -1;
      for (int k = 0; k <= 523; k++) begin
         if (cap_busy[k]) busy_cnt++;
         if (cap_done[k]) done_cnt++;
      end
      for (int k = 0; k < 520; k++)
         if (cap_tx[k] !== exp_bit(k, 4)) begin errs++; if (first_bad < 0) first_bad = k; end
      n_checks++; if (busy_cnt != 520) begin n_fail++; $display("FAIL ref_busy_len: got %0d expected 520", busy_cnt); end
      n_checks++; if (cap_busy[0] !== 1'b1 || cap_busy[520] !== 1'b0) begin
         n_fail++; $display("FAIL ref_busy_edges: got %b/%b expected 1/0", cap_busy[0], cap_busy[520]);
      end
      n_checks++; if (done_cnt != 1 || cap_done[520] !== 1'b1) begin
         n_fail++; $display("FAIL ref_done_pulse: got count %0d at520=%b expected 1/1", done_cnt, cap_done[520]);
      end
      n_checks++; if (errs != 0) begin n_fail++; $display("FAIL ref_bit_timing: got %0d bad cycles (first %0d) expected 0", errs, first_bad); end
   endtask

   task automatic test_random_frames();
      int errs, first_bad;
      for (int it = 0; it < 3; it++) begin
         rand_inputs();
         model_frame(pc, acc, ir, res, st, op);
         start_frame(1'b0);
         capture(1'b0, 4, 1, -1, -1, 1'b0);
         for (int i = 0; i < 13; i++) begin
            n_checks++; if (got[i] !== exp_q[i]) begin
               n_fail++; $display("FAIL rand%0d_byte%0d: got %h expected %h", it, i, got[i], exp_q[i]);
            end
         end
         errs = 0; first_bad = -1;
         for (int k = 0; k < 520; k++)
            if (cap_tx[k] !== exp_bit(k, 4)) begin errs++; if (first_bad < 0) first_bad = k; end
         n_checks++; if (errs != 0) begin n_fail++; $display("FAIL rand%0d_timing: got %0d bad cycles (first %0d) expected 0", it, errs, first_bad); end
         n_checks++; if (cap_done[520] !== 1'b1 || cap_busy[520] !== 1'b0) begin
            n_fail++; $display("FAIL rand%0d_end: got done=%b busy=%b expected 1/0", it, cap_done[520], cap_busy[520]);
         end
      end
   endtask

   task automatic test_snapshot();
      rand_inputs();
      model_frame(pc, acc, ir, res, st, op);
      start_frame(1'b0);
      capture(1'b0, 4, 1, -1, -1, 1'b1);
      for (int i = 0; i < 13; i++) begin
         n_checks++; if (got[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL snap_byte%0d: got %h expected %h", i, got[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_overrun();
      int ovr_cnt, busy_cnt, done_cnt;
      rand_inputs();
      model_frame(pc, acc, ir, res, st, op);
      start_frame(1'b0);
      // retrigger inside byte 3, and on the edge where the frame completes
      capture(1'b0, 4, 3, 125, 519, 1'b0);
      ovr_cnt = 0; busy_cnt = 0; done_cnt = 0;
      for (int k = 0; k <= 523; k++) begin
         if (cap_ovr[k])  ovr_cnt++;
         if (cap_busy[k]) busy_cnt++;
         if (cap_done[k]) done_cnt++;
      end
      n_checks++; if (ovr_cnt != 2) begin n_fail++; $display("FAIL ovr_count: got %0d expected 2", ovr_cnt); end
      n_checks++; if (cap_ovr[126] !== 1'b1 || cap_ovr[520] !== 1'b1) begin
         n_fail++; $display("FAIL ovr_position: got %b/%b expected 1/1", cap_ovr[126], cap_ovr[520]);
      end
      n_checks++; if (busy_cnt != 520 || done_cnt != 1) begin
         n_fail++; $display("FAIL ovr_single_frame: got busy %0d done %0d expected 520/1", busy_cnt, done_cnt);
      end
      for (int i = 0; i < 13; i++) begin
         n_checks++; if (got[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL ovr_byte%0d: got %h expected %h", i, got[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      rand_inputs();
      model_frame(pc, acc, ir, res, st, op);
      start_frame(1'b0);
      capture(1'b0, 4, 0, -1, -1, 1'b0);
      n_checks++; if (got[12] !== exp_q[12] || cap_busy[520] !== 1'b0) begin
         n_fail++; $display("FAIL b2b_first: got chk %h busy %b expected %h/0", got[12], cap_busy[520], exp_q[12]);
      end
      // trigger lands on the first edge after busy fell
      rand_inputs();
      model_frame(pc, acc, ir, res, st, op);
      start_frame(1'b0);
      capture(1'b0, 4, 2, -1, -1, 1'b0);
      n_checks++; if (cap_busy[0] !== 1'b1 || cap_tx[0] !== 1'b0) begin
         n_fail++; $display("FAIL b2b_accept: got busy %b tx %b expected 1/0", cap_busy[0], cap_tx[0]);
      end
      for (int i = 0; i < 13; i++) begin
         n_checks++; if (got[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL b2b_byte%0d: got %h expected %h", i, got[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_bit_timing();
      logic [7:0] ref_b [13];
      int errs, first_bad, busy_cnt;
      ref_b = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                8'h01, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'h07};
      pc = 16'hFFFF; acc = 16'hFFFF; ir = 16'hFFFF; res = 16'hFFFF; st = 9'h1FF; op = 4'hF;
      exp_q = ref_b;
      start_frame(1'b1);
      capture(1'b1, 7, 2, -1, -1, 1'b0);
      errs = 0; first_bad = -1; busy_cnt = 0;
      for (int k = 0; k < 910; k++)
         if (cap_tx[k] !== exp_bit(k, 7)) begin errs++; if (first_bad < 0) first_bad = k; end
      for (int k = 0; k <= 912; k++)
         if (cap_busy[k]) busy_cnt++;
      n_checks++; if (errs != 0) begin n_fail++; $display("FAIL bt7_timing: got %0d bad cycles (first %0d) expected 0", errs, first_bad); end
      n_checks++; if (busy_cnt != 910) begin n_fail++; $display("FAIL bt7_busy_len: got %0d expected 910", busy_cnt); end
      n_checks++; if (cap_done[910] !== 1'b1) begin n_fail++; $display("FAIL bt7_done: got %b expected 1", cap_done[910]); end
      for (int i = 0; i < 13; i++) begin
         n_checks++; if (got[i] !== ref_b[i]) begin
            n_fail++; $display("FAIL bt7_byte%0d: got %h expected %h", i, got[i], ref_b[i]);
         end
      end
   endtask

   task automatic test_reset_midframe();
      rand_inputs();
      start_frame(1'b0);
      // walk into data bit 2 of byte 5
      repeat (214) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_checks++; if (tx4 !== 1'b1) begin n_fail++; $display("FAIL midrst_tx: got %b expected 1", tx4); end
      n_checks++; if (busy4 !== 1'b0 || done4 !== 1'b0 || ovr4 !== 1'b0) begin
         n_fail++; $display("FAIL midrst_flags: got busy %b done %b ovr %b expected 0/0/0", busy4, done4, ovr4);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      rand_inputs();
      model_frame(pc, acc, ir, res, st, op);
      start_frame(1'b0);
      capture(1'b0, 4, 1, -1, -1, 1'b0);
      for (int i = 0; i < 13; i++) begin
         n_checks++; if (got[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL midrst_byte%0d: got %h expected %h", i, got[i], exp_q[i]);
         end
      end
      n_checks++; if (cap_done[520] !== 1'b1) begin n_fail++; $display("FAIL midrst_done: got %b expected 1", cap_done[520]); end
   endtask

   initial begin
      test_reset();
      test_reference();
      test_random_frames();
      test_snapshot();
      test_overrun();
      test_back_to_back();
      test_bit_timing();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dbg_frame_tx.md
# dbg_frame_tx

Debug snapshot transmitter for the MU0 board. On a trigger it captures the CPU debug state (PC, ACC, IR, state, ALU result, ALU op) in one cycle. It serialises the snapshot as a framed, checksummed byte stream on a UART 8N1 output, so the host can trace execution without polling over the command channel. It sits beside the MU0 core and is fed from the same debug buses the command UART uses.

## Interface

Parameters:
- CLKS_PER_BIT, 234: clock cycles per UART bit (27 MHz / 115200); must be ≥ 2.
- SYNC_BYTE, 8'hA5: first byte of every frame.

Ports:
- clk  input  1  system clock; one clock.
- reset  input  1  asynchronous, active-high reset.
- trigger  input  1  single-cycle capture request.
- dbgPc  input  16  program counter.
- dbgAcc  input  16  accumulator.
- dbgIr  input  16  instruction register.
- dbgState  input  9  core state vector.
- dbgAluResult  input  16  ALU result.
- dbgAluOp  input  4  ALU opcode.
- tx  output  1  UART serial out; idles high.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse when the last stop bit completes.
- overrun  output  1  one-cycle pulse when a trigger arrives while busy.

## Operation

- Frame: 13 bytes, sent in this order:
  - SYNC_BYTE.
  - dbgPc[15:8], dbgPc[7:0].
  - dbgAcc hi, lo.
  - dbgIr hi, lo.
  - {7'b0, dbgState[8]}, dbgState[7:0].
  - dbgAluResult hi, lo.
  - {4'b0, dbgAluOp}.
  - CHK.
- CHK is the sum of the 11 payload bytes mod 256. SYNC_BYTE is excluded.
- Byte format: start bit (0), 8 data bits LSB first, stop bit (1). There is no gap between bytes.
- All fields are latched into a snapshot register on the trigger cycle. Input changes after that do not affect the frame in flight.
- FSM states:
  - IDLE: tx=1, busy=0. A trigger loads the snapshot and the byte index (0), then goes to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, each held CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If the byte index is 12, pulse frame_done and go to IDLE. Otherwise increment the index and go to START.
- The checksum accumulates as payload bytes are loaded, or is computed combinationally from the snapshot. Either way it must equal the mod-256 sum above.
- A trigger in any state other than IDLE is ignored and pulses overrun for one cycle. The frame in progress is unaffected.
- A trigger on the same cycle as the frame_done transition to IDLE is ignored and pulses overrun. Triggers are accepted only when the registered state is IDLE.
- Reset, asynchronous and at any time including mid-bit:
  - tx=1, busy=0, frame_done=0, overrun=0.
  - FSM=IDLE, bit/byte/baud counters cleared.
  - The partial frame is abandoned.

## Timing

- Trigger sampled high at rising edge T while IDLE: busy=1 and tx=0 from T+1.
- Each bit lasts exactly CLKS_PER_BIT cycles. The baud counter runs from 0 to CLKS_PER_BIT-1 and wraps.
- Frame duration: 130·CLKS_PER_BIT cycles from T+1.
- busy drops and frame_done pulses on the same cycle, 130·CLKS_PER_BIT cycles after T+1.
- The earliest accepted re-trigger is the cycle after busy drops.
- Outputs are registered; tx has no combinational path from the inputs.
- overrun is asserted on the cycle after the offending trigger edge.

## Test plan

- **Reset values:** assert reset mid-DATA of byte 5 (CLKS_PER_BIT=4) -> tx=1 and busy=0 immediately, without waiting for a clock. After release, a new trigger produces a full, correct 13-byte frame.
- **Reference frame** (CLKS_PER_BIT=4), with pc=0x0012, acc=0xBEEF, ir=0x3004, state=0x101, aluResult=0x00FF, aluOp=0x7:
  - Trigger -> the decoded bytes are A5 00 12 BE EF 30 04 01 01 00 FF 07 FB.
  - busy is high for exactly 520 cycles.
  - frame_done is a single pulse.
- **Snapshot isolation:** change every dbg input one cycle after the trigger -> the frame still carries the trigger-cycle values.
- **Overrun:** trigger again at byte 3, and again on the frame_done cycle -> two one-cycle overrun pulses, exactly one frame emitted. A trigger one cycle after busy falls starts a second frame.
- **Bit timing and checksum wrap:** CLKS_PER_BIT=7, all inputs 0xFFFF/0x1FF/0xF:
  - Every bit lasts 7 cycles.
  - Payload bytes: FF FF FF FF FF FF 01 FF FF FF 0F.
  - CHK = 0x07, since 9·0xFF + 0x01 + 0x0F = 0x907 and mod 256 gives 0x07.
